pong_engine: RTL

Parametrised game-state engine for two-player Pong. It owns ball position and velocity, both paddle positions, scores and the serve/point/game-over sequencing, advancing once per video frame. It sits between the debounced pushbutton inputs and the box-drawing/colour logic that feeds the VGA driver. All outputs are registered coordinates; it performs no pixel work.

---
 rtl/pong_pkg.sv | 7 +
 rtl/pong_paddle.sv | 33 +++
 rtl/pong_engine.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/pong_pkg.sv
// pong_pkg: shared state encoding and coordinate/velocity types for the pong engine.
package pong_pkg;
    localparam int COORD_BITS = 10;
    typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, POINT = 2'd2, OVER = 2'd3} state_t;
    typedef logic [COORD_BITS-1:0] coord_t;
    typedef logic signed [COORD_BITS+1:0] vel_t;
endpackage

// File: rtl/pong_paddle.sv
// pong_paddle: one paddle's vertical position with up/down motion, clamping, freeze and recentre.
module pong_paddle
    import pong_pkg::*;
#(
    parameter int COORD_W    = COORD_BITS,
    parameter int SCREEN_H   = 480,
    parameter int PADDLE_H   = 50,
    parameter int PADDLE_SPD = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en_i,
    input  logic               centre_i,
    input  logic               up_i,
    input  logic               down_i,
    output logic [COORD_W-1:0] y_o
);
    typedef logic signed [COORD_W+1:0] sw_t;
    localparam sw_t Z = sw_t'(0);
    localparam sw_t Y_MAX = sw_t'(SCREEN_H - PADDLE_H);
    localparam sw_t SPD = sw_t'(PADDLE_SPD);
    localparam logic [COORD_W-1:0] Y_MID = COORD_W'((SCREEN_H - PADDLE_H) / 2);
    logic [COORD_W-1:0] y_q, y_d;
    sw_t ny;
    always_comb begin
        ny = sw_t'(y_q) + ((up_i && !down_i) ? -SPD : (down_i && !up_i) ? SPD : Z);
        y_d = centre_i ? Y_MID : !en_i ? y_q : ny < Z ? '0 : ny > Y_MAX ? COORD_W'(Y_MAX) : COORD_W'(ny);
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) y_q <= Y_MID;
        else y_q <= y_d;
    assign y_o = y_q;
endmodule

// File: rtl/pong_engine.sv
// pong_engine: per-frame Pong game state (ball, paddles, scores, serve/point/over sequencing).
// Define PONG_SPEEDUP_EN to add 1 to |vx| on every paddle hit, saturating at VX_MAX.
module pong_engine
    import pong_pkg::*;
#(
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int COORD_W     = COORD_BITS,
    parameter int PADDLE_W    = 10,
    parameter int PADDLE_H    = 50,
    parameter int BALL_SZ     = 8,
    parameter int P1_X        = 20,
    parameter int P2_X        = 610,
    parameter int PADDLE_SPD  = 3,
    parameter int VX0         = 3,
    parameter int VY0         = 1,
    parameter int VX_MAX      = 7,
    parameter int SCORE_MAX   = 9,
    parameter int HOLD_FRAMES = 60
) (
    input  logic               CLOCK_50,
    input  logic               reset_n,
    input  logic               frame_tick,
    input  logic               p1_up,
    input  logic               p1_down,
    input  logic               p2_up,
    input  logic               p2_down,
    input  logic               serve,
    output logic [COORD_W-1:0] ball_x,
    output logic [COORD_W-1:0] ball_y,
    output logic [COORD_W-1:0] p1_y,
    output logic [COORD_W-1:0] p2_y,
    output logic [3:0]         score_p1,
    output logic [3:0]         score_p2,
    output logic [1:0]         state,
    output logic               game_over
);
    typedef logic signed [COORD_W+1:0] sw_t;
    localparam int VM = $bits(vel_t) - 1;
    localparam sw_t Z = sw_t'(0);
    localparam sw_t B = sw_t'(BALL_SZ);
    localparam sw_t PH = sw_t'(PADDLE_H);
    localparam sw_t X1R = sw_t'(P1_X + PADDLE_W);
    localparam sw_t X1L = sw_t'(P1_X - BALL_SZ);
    localparam sw_t X2L = sw_t'(P2_X - BALL_SZ);
    localparam sw_t X2R = sw_t'(P2_X + PADDLE_W);
    localparam sw_t XLIM = sw_t'(SCREEN_W - BALL_SZ);
    localparam sw_t YLIM = sw_t'(SCREEN_H - BALL_SZ);
    localparam logic [COORD_W-1:0] BX_MID = COORD_W'(SCREEN_W / 2 - BALL_SZ / 2);
    localparam logic [COORD_W-1:0] BY_MID = COORD_W'(SCREEN_H / 2 - BALL_SZ / 2);
    localparam logic [3:0] S_MAX = 4'(SCORE_MAX);
    localparam logic [15:0] H_LAST = 16'(HOLD_FRAMES - 1);
    localparam vel_t V0 = vel_t'(VX0);
    localparam vel_t VY = vel_t'(VY0);
    localparam vel_t VMAX = vel_t'(VX_MAX);
`ifdef PONG_SPEEDUP_EN
    localparam vel_t V_INC = vel_t'(1);
`else
    localparam vel_t V_INC = vel_t'(0);
`endif
    state_t state_q, state_d;
    logic [COORD_W-1:0] bx_q, bx_d, by_q, by_d, p1_q, p2_q;
    vel_t vx_q, vx_d, vy_q, vy_d, vxa, vya, vhit;
    logic [3:0] s1_q, s1_d, s2_q, s2_d;
    logic [15:0] hold_q, hold_d;
    logic dir_q, dir_d, serve_q, pend_q, pend_d, sedge, go, hit1, hit2, miss_l, miss_r;
    sw_t nx, ny, p1s, p2s;

    assign sedge = serve && !serve_q;
    assign go = pend_q || sedge;
    // Edges seen during POINT are dropped; any tick consumes whatever is pending.
    assign pend_d = !frame_tick && (pend_q || (sedge && state_q != POINT));

    pong_paddle #(.COORD_W(COORD_W), .SCREEN_H(SCREEN_H), .PADDLE_H(PADDLE_H), .PADDLE_SPD(PADDLE_SPD)) u_p1 (
        .clk(CLOCK_50), .rst_n(reset_n), .en_i(frame_tick && state_q != OVER),
        .centre_i(frame_tick && state_q == OVER && go), .up_i(p1_up), .down_i(p1_down), .y_o(p1_q)
    );
    pong_paddle #(.COORD_W(COORD_W), .SCREEN_H(SCREEN_H), .PADDLE_H(PADDLE_H), .PADDLE_SPD(PADDLE_SPD)) u_p2 (
        .clk(CLOCK_50), .rst_n(reset_n), .en_i(frame_tick && state_q != OVER),
        .centre_i(frame_tick && state_q == OVER && go), .up_i(p2_up), .down_i(p2_down), .y_o(p2_q)
    );

    always_comb begin
        nx = sw_t'(bx_q) + sw_t'(vx_q);
        ny = sw_t'(by_q) + sw_t'(vy_q);
        p1s = sw_t'(p1_q);
        p2s = sw_t'(p2_q);
        vxa = vx_q[VM] ? -vx_q : vx_q;
        vya = vy_q[VM] ? -vy_q : vy_q;
        vhit = (V_INC != '0 && vxa >= VMAX) ? VMAX : vxa + V_INC;
        hit1 = vx_q[VM] && nx <= X1R && nx > X1L && ny + B > p1s && ny < p1s + PH;
        hit2 = !vx_q[VM] && vx_q != '0 && nx >= X2L && nx < X2R && ny + B > p2s && ny < p2s + PH;
        miss_l = !hit1 && !hit2 && nx <= Z;
        miss_r = !hit1 && !hit2 && !miss_l && nx >= XLIM;
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n)
        if (!reset_n) state_q <= IDLE;
        else state_q <= state_d;

    always_comb begin
        state_d = state_q;
        if (frame_tick)
            case (state_q)
                IDLE:    state_d = go ? PLAY : IDLE;
                PLAY:    state_d = (miss_l || miss_r) ? POINT : PLAY;
                POINT:   state_d = hold_q != H_LAST ? POINT : (s1_q == S_MAX || s2_q == S_MAX) ? OVER : IDLE;
                default: state_d = go ? IDLE : OVER;
            endcase
    end

    always_comb begin
        bx_d = bx_q;
        by_d = by_q;
        vx_d = vx_q;
        vy_d = vy_q;
        s1_d = s1_q;
        s2_d = s2_q;
        hold_d = hold_q;
        dir_d = dir_q;
        if (frame_tick)
            case (state_q)
                IDLE: if (go) begin
                    vx_d = dir_q ? V0 : -V0;
                    vy_d = -VY;
                end
                PLAY: begin
                    by_d = ny <= Z ? '0 : ny >= YLIM ? COORD_W'(YLIM) : COORD_W'(ny);
                    vy_d = ny <= Z ? vya : ny >= YLIM ? -vya : vy_q;
                    bx_d = hit1 ? COORD_W'(X1R) : hit2 ? COORD_W'(X2L) : nx <= Z ? '0 : nx >= XLIM ? COORD_W'(XLIM) : COORD_W'(nx);
                    vx_d = hit1 ? vhit : hit2 ? -vhit : vx_q;
                    hold_d = '0;
                    s2_d = (miss_l && s2_q < S_MAX) ? s2_q + 4'd1 : s2_q;
                    s1_d = (miss_r && s1_q < S_MAX) ? s1_q + 4'd1 : s1_q;
                    dir_d = miss_l ? 1'b0 : miss_r ? 1'b1 : dir_q;
                end
                POINT: begin
                    hold_d = hold_q + 16'd1;
                    if (hold_q == H_LAST) begin
                        bx_d = BX_MID;
                        by_d = BY_MID;
                        vx_d = '0;
                        vy_d = '0;
                        hold_d = '0;
                    end
                end
                default: if (go) begin
                    s1_d = '0;
                    s2_d = '0;
                    bx_d = BX_MID;
                    by_d = BY_MID;
                end
            endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n)
        if (!reset_n) begin
            bx_q <= BX_MID;
            by_q <= BY_MID;
            vx_q <= '0;
            vy_q <= '0;
            s1_q <= '0;
            s2_q <= '0;
            hold_q <= '0;
            dir_q <= 1'b1;
            serve_q <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            bx_q <= bx_d;
            by_q <= by_d;
            vx_q <= vx_d;
            vy_q <= vy_d;
            s1_q <= s1_d;
            s2_q <= s2_d;
            hold_q <= hold_d;
            dir_q <= dir_d;
            serve_q <= serve;
            pend_q <= pend_d;
        end

    always_comb begin
        ball_x = bx_q;
        ball_y = by_q;
        p1_y = p1_q;
        p2_y = p2_q;
        score_p1 = s1_q;
        score_p2 = s2_q;
        state = state_q;
        game_over = state_q == OVER;
    end
endmodule
